// File: rtl/pos_cache_pkg.sv
// Shared definitions for the position cache: FSM state encoding,
// per-channel field widths and the cell-ID packing helper.
package pos_cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COLLECT   = 2'd1,
      ST_WRITE_NUM = 2'd2,
      ST_SWAP      = 2'd3
   } state_t;

   localparam int NUM_AXES = 3;

   // Width of one {posz,posy,posx} record on a broadcast channel.
   function automatic int pos_field_width(input int dw);
      return NUM_AXES * dw;
   endfunction

   // Width of one {x,y,z} destination-cell tag on a broadcast channel.
   function automatic int cell_field_width(input int cw);
      return NUM_AXES * cw;
   endfunction

   // Packs cell coordinates as {x,y,z}, each w bits wide, zero-extended to 32 bits.
   function automatic logic [31:0] pack_cell(input int x, input int y, input int z, input int w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return ((32'(x) & mask) << (2 * w)) | ((32'(y) & mask) << w) | (32'(z) & mask);
   endfunction

endpackage

// File: rtl/pos_cache_bank.sv
// Single-port position bank: one address shared by read and write,
// registered read data.
module pos_cache_bank
   import pos_cache_pkg::*;
#(
   parameter int    WIDTH      = 96,
   parameter int    ADDR_WIDTH = 8,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  rden,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port share one address.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (rden) rdata <= mem[addr];
   end

endmodule

// File: rtl/pos_cache_db.sv
// Double-buffered particle position cache for one cell.
// The active bank serves reads while motion updates addressed to this cell
// are collected into the shadow bank; the banks swap at the end of the window.
// Address 0 of each bank holds the particle count.
// Optional build macro POS_CACHE_OVF_CHECK_EN: sticky overflow flag on
// accepts beyond PARTICLE_NUM (otherwise overflow is tied low).
//
// state        | meaning
// ST_IDLE      | no update; a matched accept here (enable high) starts collection
// ST_COLLECT   | accepting matched channel data into the shadow bank
// ST_WRITE_NUM | writing the collected count to shadow address 0
// ST_SWAP      | flipping bank select, publishing the new count
module pos_cache_db
   import pos_cache_pkg::*;
#(
   parameter int    DATA_WIDTH    = 32,
   parameter int    PARTICLE_NUM  = 220,
   parameter int    ADDR_WIDTH    = 8,
   parameter int    CELL_ID_WIDTH = 4,
   parameter int    CELL_X        = 1,
   parameter int    CELL_Y        = 1,
   parameter int    CELL_Z        = 1,
   parameter int    NUM_CH        = 2,
   parameter string INIT_FILE     = ""
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                motion_update_enable,
   input  logic [ADDR_WIDTH-1:0]               in_read_address,
   input  logic                                in_rden,
   input  logic [NUM_CH*3*DATA_WIDTH-1:0]      in_data,
   input  logic [NUM_CH*3*CELL_ID_WIDTH-1:0]   in_data_dst_cell,
   input  logic [NUM_CH-1:0]                   in_data_valid,
   output logic [NUM_CH-1:0]                   in_data_ready,
   output logic [3*DATA_WIDTH-1:0]             out_particle_info,
   output logic                                out_valid,
   output logic                                busy,
   output logic                                swap_done,
   output logic [ADDR_WIDTH-1:0]               particle_count,
   output logic                                overflow
);

   localparam int          POS_W   = pos_field_width(DATA_WIDTH);
   localparam int          CID_W   = cell_field_width(CELL_ID_WIDTH);
   localparam int          CNT_W   = ADDR_WIDTH + 1;
   localparam logic [31:0] MY_CELL = pack_cell(CELL_X, CELL_Y, CELL_Z, CELL_ID_WIDTH);

   state_t                 state, state_nxt;
   logic                   bank_sel;
   logic                   rd_sel;
   logic [CNT_W-1:0]       new_counter;
   logic [ADDR_WIDTH-1:0]  count_val;
   logic                   wr_pending;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [POS_W-1:0]       wr_data;
   logic                   window;
   logic                   acc_any;
   logic                   acc_room;
   logic [POS_W-1:0]       acc_data;
   logic [NUM_CH-1:0]      ready_c;
   logic                   sh_we;
   logic [ADDR_WIDTH-1:0]  sh_addr;
   logic [POS_W-1:0]       sh_wdata;
   logic [POS_W-1:0]       rdata0, rdata1;

   assign window    = motion_update_enable && (state == ST_IDLE || state == ST_COLLECT);
   assign acc_room  = new_counter <= CNT_W'(PARTICLE_NUM);
   assign count_val = ADDR_WIDTH'(new_counter - CNT_W'(1));

   // Channel arbitration: pass-through for foreign cells, lowest matched index wins.
   always_comb begin
      ready_c  = '0;
      acc_any  = 1'b0;
      acc_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (in_data_valid[i] && (32'(in_data_dst_cell[i*CID_W +: CID_W]) != MY_CELL)) begin
            ready_c[i] = 1'b1;
         end else if (in_data_valid[i] && window && !acc_any) begin
            ready_c[i] = 1'b1;
            acc_any    = 1'b1;
            acc_data   = in_data[i*POS_W +: POS_W];
         end
      end
   end

   assign in_data_ready = rst ? '0 : ready_c;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and busy decode.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (motion_update_enable) state_nxt = ST_COLLECT;
         end
         ST_COLLECT:   if (!motion_update_enable) state_nxt = ST_WRITE_NUM;
         ST_WRITE_NUM: state_nxt = ST_SWAP;
         ST_SWAP:      state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Accept register and fill counter; counter saturates at PARTICLE_NUM+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         new_counter <= CNT_W'(1);
         wr_pending  <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         wr_pending <= 1'b0;
         if (state == ST_SWAP) begin
            new_counter <= CNT_W'(1);
         end else if (acc_any && acc_room) begin
            wr_pending  <= 1'b1;
            wr_addr     <= new_counter[ADDR_WIDTH-1:0];
            wr_data     <= acc_data;
            new_counter <= new_counter + CNT_W'(1);
         end
      end
   end

`ifdef POS_CACHE_OVF_CHECK_EN
   // Sticky overflow, cleared when a new collection window opens.
   always_ff @(posedge clk) begin
      if (rst)                                            overflow <= 1'b0;
      else if (state == ST_IDLE && motion_update_enable)  overflow <= 1'b0;
      else if (acc_any && !acc_room)                      overflow <= 1'b1;
   end
`else
   assign overflow = 1'b0;
`endif

   // Bank swap, swap_done pulse and published count.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_sel       <= 1'b0;
         swap_done      <= 1'b0;
         particle_count <= '0;
      end else begin
         swap_done <= (state == ST_SWAP);
         if (state == ST_SWAP) begin
            bank_sel       <= ~bank_sel;
            particle_count <= count_val;
         end
      end
   end

   // Read-valid and the bank select that travels with each read.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         rd_sel    <= 1'b0;
      end else begin
         out_valid <= in_rden;
         if (in_rden) rd_sel <= bank_sel;
      end
   end

   // Shadow write source: count word in WRITE_NUM, otherwise the pending accept.
   always_comb begin
      sh_we    = 1'b0;
      sh_addr  = wr_addr;
      sh_wdata = wr_data;
      if (state == ST_WRITE_NUM) begin
         sh_we    = 1'b1;
         sh_addr  = '0;
         sh_wdata = POS_W'(count_val);
      end else if (wr_pending) begin
         sh_we = 1'b1;
      end
      if (rst) sh_we = 1'b0;
   end

   pos_cache_bank #(
      .WIDTH      (POS_W),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_bank0 (
      .clk   (clk),
      .we    (sh_we && bank_sel),
      .rden  (in_rden && !bank_sel),
      .addr  (bank_sel ? sh_addr : in_read_address),
      .wdata (sh_wdata),
      .rdata (rdata0)
   );

   pos_cache_bank #(
      .WIDTH      (POS_W),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  ("")
   ) u_bank1 (
      .clk   (clk),
      .we    (sh_we && !bank_sel),
      .rden  (in_rden && bank_sel),
      .addr  (bank_sel ? in_read_address : sh_addr),
      .wdata (sh_wdata),
      .rdata (rdata1)
   );

   assign out_particle_info = rd_sel ? rdata1 : rdata0;

endmodule

// File: tb/tb_pos_cache_db.sv
// Scoreboard bench for pos_cache_db: reads push expected data with a due
// cycle; a negedge monitor pops and compares whenever out_valid is high.
module tb_pos_cache_db;

   localparam int DW   = 32;
   localparam int PN   = 12;
   localparam int AW   = 8;
   localparam int CW   = 4;
   localparam int NCH  = 2;
   localparam int PW   = 3 * DW;
   localparam int CIDW = 3 * CW;
   localparam logic [CIDW-1:0] MYCELL = 12'h111;
   localparam logic [CIDW-1:0] FOREIGN = 12'h211;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [AW-1:0]        raddr;
   logic                 rden;
   logic [NCH*PW-1:0]    din;
   logic [NCH*CIDW-1:0]  dcell;
   logic [NCH-1:0]       dvalid;
   logic [NCH-1:0]       dready;
   logic [PW-1:0]        pinfo;
   logic                 ovalid;
   logic                 busy;
   logic                 swap_done;
   logic [AW-1:0]        pcount;
   logic                 ovf;

   pos_cache_db #(
      .DATA_WIDTH    (DW),
      .PARTICLE_NUM  (PN),
      .ADDR_WIDTH    (AW),
      .CELL_ID_WIDTH (CW),
      .CELL_X        (1),
      .CELL_Y        (1),
      .CELL_Z        (1),
      .NUM_CH        (NCH),
      .INIT_FILE     ("")
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .motion_update_enable (en),
      .in_read_address      (raddr),
      .in_rden              (rden),
      .in_data              (din),
      .in_data_dst_cell     (dcell),
      .in_data_valid        (dvalid),
      .in_data_ready        (dready),
      .out_particle_info    (pinfo),
      .out_valid            (ovalid),
      .busy                 (busy),
      .swap_done            (swap_done),
      .particle_count       (pcount),
      .overflow             (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [PW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sbq[$];
   logic [PW-1:0] model [2][16];
   bit            bank_known [2];
   int            sb_active = 0;
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] mkdata(input int tag, input int k);
      return {32'(tag * 1000 + 300 + k), 32'(tag * 1000 + 200 + k), 32'(tag * 1000 + 100 + k)};
   endfunction

   // Monitor: flag overdue reads, then compare each presented read result.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            check("read_missing", 0, e.data);
         end
         if (ovalid === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL read_unexpected: got %0h expected none", pinfo);
            end else begin
               e = sbq.pop_front();
               check("read_data", pinfo, e.data);
               check("read_latency", cyc, e.due);
            end
         end
      end
   end

   task automatic do_read(input int a);
      @(posedge clk); #1;
      rden  = 1'b1;
      raddr = AW'(a);
      sbq.push_back('{data: model[sb_active][a], due: cyc + 1});
      @(posedge clk); #1;
      rden = 1'b0;
   endtask

   task automatic run_update(input int n, input int tag, input logic ch0v, input logic ch1v,
                             input logic [CIDW-1:0] ch1cell);
      int            cnt;
      int            shadow;
      logic          exp_ovf;
      logic [1:0]    exp_rdy;
      logic [PW-1:0] d0, d1, dacc;
      logic          acc;
      cnt     = 1;
      shadow  = 1 - sb_active;
      exp_ovf = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         d0     = mkdata(tag, k);
         d1     = mkdata(tag + 50, k);
         en     = 1'b1;
         din    = {d1, d0};
         dcell  = {ch1cell, MYCELL};
         dvalid = {ch1v, ch0v};
         rden   = 1'b0;
         if (k == 1 && bank_known[sb_active]) begin
            rden  = 1'b1;
            raddr = 8'd3;
            sbq.push_back('{data: model[sb_active][3], due: cyc + 1});
         end
         #1;
         exp_rdy[0] = ch0v;
         exp_rdy[1] = ch1v && (ch1cell != MYCELL || !ch0v);
         check("ready_collect", dready, exp_rdy);
         acc  = 1'b0;
         dacc = '0;
         if (ch0v) begin
            acc  = 1'b1;
            dacc = d0;
         end else if (ch1v && ch1cell == MYCELL) begin
            acc  = 1'b1;
            dacc = d1;
         end
         if (acc) begin
`ifdef POS_CACHE_OVF_CHECK_EN
            if (cnt > PN) exp_ovf = 1'b1;
`endif
            if (cnt <= PN) begin
               model[shadow][cnt] = dacc;
               cnt++;
            end
         end
      end
      @(posedge clk); #1;
      en     = 1'b0;
      dvalid = '0;
      rden   = 1'b0;
      check("busy_collect", busy, 1'b1);
      @(posedge clk); #1;
      dvalid = 2'b01;
      #1;
      check("ready_write_num", dready, 2'b00);
      check("busy_write_num", busy, 1'b1);
      check("swap_early", swap_done, 1'b0);
      @(posedge clk); #1;
      dvalid = '0;
      check("busy_swap", busy, 1'b1);
      if (bank_known[sb_active]) begin
         rden  = 1'b1;
         raddr = '0;
         sbq.push_back('{data: model[sb_active][0], due: cyc + 1});
      end
      @(posedge clk); #1;
      rden = 1'b0;
      check("swap_done", swap_done, 1'b1);
      check("particle_count", pcount, cnt - 1);
      check("overflow", ovf, exp_ovf);
      model[shadow][0]   = PW'(cnt - 1);
      bank_known[shadow] = 1'b1;
      sb_active          = shadow;
      @(posedge clk); #1;
      check("swap_pulse_end", swap_done, 1'b0);
      check("busy_idle", busy, 1'b0);
      for (int a = 0; a < cnt; a++) do_read(a);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int            shadow;
      logic [PW-1:0] d0;
      rst    = 1'b1;
      en     = 1'b0;
      rden   = 1'b0;
      raddr  = '0;
      din    = '0;
      dcell  = '0;
      dvalid = '0;
      bank_known[0] = 1'b0;
      bank_known[1] = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      dcell  = {FOREIGN, MYCELL};
      dvalid = 2'b10;
      #1;
      check("ready_in_rst", dready, 2'b00);
      dvalid = '0;
      @(posedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      check("rst_count", pcount, 0);
      check("rst_overflow", ovf, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_swap_done", swap_done, 1'b0);
      check("rst_out_valid", ovalid, 1'b0);

      // Both channels matching: only ch0 accepted.
      run_update(10, 1, 1'b1, 1'b1, MYCELL);
      // ch1 addressed to a foreign cell: pass-through, no write.
      run_update(5, 2, 1'b1, 1'b1, FOREIGN);
      // Only ch1 matching, more accepts than PARTICLE_NUM.
      run_update(PN + 2, 3, 1'b0, 1'b1, MYCELL);

      // Partial update into bank 0, then reset mid-collection.
      shadow = 1 - sb_active;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         d0     = mkdata(4, k);
         en     = 1'b1;
         din    = {mkdata(60, k), d0};
         dcell  = {FOREIGN, MYCELL};
         dvalid = 2'b01;
         model[shadow][k + 1] = d0;
      end
      @(posedge clk); #1;
      dvalid = '0;
      @(posedge clk); #1;
      check("busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk); #1;
      rst       = 1'b0;
      sb_active = 0;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_count", pcount, 0);
      check("mid_rst_overflow", ovf, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("no_swap_after_rst", swap_done, 1'b0);
      end
      for (int a = 0; a < 6; a++) do_read(a);

      repeat (3) @(posedge clk);
      #1;
      check("read_queue_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
